// File: rtl/rfaludm_pkg.sv
// Shared encodings for the multicycle register-file / ALU / data-memory datapath.
package rfaludm_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_t;

endpackage

// File: rtl/rfaludm_alu.sv
// Combinational ALU: AND/OR/ADD/SUB/signed SLT/NOR, zero for unknown codes.
module rfaludm_alu
  import rfaludm_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Operation select; ADD/SUB wrap at WIDTH bits.
  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rf_alu_dm_mc.sv
// Multicycle datapath: latches one decoded instruction on Start, then runs
// EXEC -> (MEM) -> WB, owning the register file and data memory.
module rf_alu_dm_mc
  import rfaludm_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned DM_DEPTH = 256
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [$clog2(NREGS)-1:0]   Read1,
  input  logic [$clog2(NREGS)-1:0]   Read2,
  input  logic [$clog2(NREGS)-1:0]   ins_15_11,
  input  logic [15:0]                SEin,
  input  logic                       RegDst,
  input  logic                       RegWrite,
  input  logic                       ALUSrc,
  input  logic                       MemtoReg,
  input  logic                       MemWrite,
  input  logic                       MemRead,
  input  logic [3:0]                 ALUOp,
  output logic                       Busy,
  output logic                       Done,
  output logic [WIDTH-1:0]           Result,
  output logic                       Zero
);

  localparam int unsigned RAW = $clog2(NREGS);
  localparam int unsigned DAW = $clog2(DM_DEPTH);

  state_t state_q, state_d;

  logic [RAW-1:0]   r1_q, r2_q, rd_q;
  logic [15:0]      imm_q;
  logic [3:0]       op_q;
  logic             regdst_q, regwrite_q, alusrc_q, memtoreg_q, memwrite_q, memread_q;

  logic [WIDTH-1:0] rf [NREGS];
  logic [WIDTH-1:0] dm [DM_DEPTH];

  logic [WIDTH-1:0] alu_out_q, mdr_q, result_q;
  logic             zero_q;

  logic [WIDTH-1:0] a_val, b_reg, b_val, imm_ext, alu_y, wb_data, wb_result;
  logic [RAW-1:0]   dest;
  logic [DAW-1:0]   dm_addr;
  logic             mem_op;

  assign imm_ext = WIDTH'($signed(imm_q));
  assign a_val   = (r1_q == '0) ? '0 : rf[r1_q];
  assign b_reg   = (r2_q == '0) ? '0 : rf[r2_q];
  assign b_val   = alusrc_q ? imm_ext : b_reg;
  assign mem_op  = memread_q | memwrite_q;
  assign dm_addr = alu_out_q[DAW-1:0];
  assign dest    = regdst_q ? rd_q : r2_q;
  assign wb_data = memtoreg_q ? mdr_q : alu_out_q;
  assign wb_result = regwrite_q ? wb_data : alu_out_q;

  rfaludm_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (a_val),
    .b  (b_val),
    .y  (alu_y)
  );

  // State register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and status outputs.
  always_comb begin
    state_d = state_q;
    Busy    = (state_q != S_IDLE);
    Done    = (state_q == S_WB);
    case (state_q)
      S_IDLE:  if (Start) state_d = S_EXEC;
      S_EXEC:  state_d = mem_op ? S_MEM : S_WB;
      S_MEM:   state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result is presented live during WB and then held from the stored copy,
  // so it is valid in the same cycle as Done without an extra stage.
  always_comb begin
    Result = result_q;
    if (state_q == S_WB) Result = wb_result;
  end

  assign Zero = zero_q;

  // Instruction latch, ALU output register and held result.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r1_q       <= '0;
      r2_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      op_q       <= '0;
      regdst_q   <= 1'b0;
      regwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      alu_out_q  <= '0;
      zero_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            r1_q       <= Read1;
            r2_q       <= Read2;
            rd_q       <= ins_15_11;
            imm_q      <= SEin;
            op_q       <= ALUOp;
            regdst_q   <= RegDst;
            regwrite_q <= RegWrite;
            alusrc_q   <= ALUSrc;
            memtoreg_q <= MemtoReg;
            memwrite_q <= MemWrite;
            memread_q  <= MemRead;
          end
        end
        S_EXEC: begin
          alu_out_q <= alu_y;
          zero_q    <= (alu_y == '0);
        end
        S_WB:    result_q <= wb_result;
        default: ;
      endcase
    end
  end

  // Register file: cleared on reset, written on the WB -> IDLE edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (state_q == S_WB && regwrite_q && dest != '0) begin
      rf[dest] <= wb_data;
    end
  end

  // Data memory with synchronous read; a combined read/write sees old data.
  always_ff @(posedge Clock) begin
    if (state_q == S_MEM) begin
      if (memread_q)  mdr_q       <= dm[dm_addr];
      if (memwrite_q) dm[dm_addr] <= b_reg;
    end
  end

endmodule

// File: tb/tb_rf_alu_dm_mc.sv
// Scoreboard bench for rf_alu_dm_mc: default-size and 16-bit instances.
module tb_rf_alu_dm_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_m, start_s;
  logic [4:0]  read1, read2, ins_rd;
  logic [15:0] sein;
  logic        regdst, regwrite, alusrc, memtoreg, memwrite, memread;
  logic [3:0]  aluop;

  logic        m_busy, m_done, m_zero;
  logic [31:0] m_result;
  logic        s_busy, s_done, s_zero;
  logic [15:0] s_result;

  always #5 clk = ~clk;

  rf_alu_dm_mc dut_m (
    .Clock(clk), .Reset(rst), .Start(start_m),
    .Read1(read1), .Read2(read2), .ins_15_11(ins_rd), .SEin(sein),
    .RegDst(regdst), .RegWrite(regwrite), .ALUSrc(alusrc), .MemtoReg(memtoreg),
    .MemWrite(memwrite), .MemRead(memread), .ALUOp(aluop),
    .Busy(m_busy), .Done(m_done), .Result(m_result), .Zero(m_zero)
  );

  rf_alu_dm_mc #(.WIDTH(16), .NREGS(8), .DM_DEPTH(16)) dut_s (
    .Clock(clk), .Reset(rst), .Start(start_s),
    .Read1(read1[2:0]), .Read2(read2[2:0]), .ins_15_11(ins_rd[2:0]), .SEin(sein),
    .RegDst(regdst), .RegWrite(regwrite), .ALUSrc(alusrc), .MemtoReg(memtoreg),
    .MemWrite(memwrite), .MemRead(memread), .ALUOp(aluop),
    .Busy(s_busy), .Done(s_done), .Result(s_result), .Zero(s_zero)
  );

  typedef struct {
    logic [3:0]  op;
    int          r1, r2, rd;
    logic [15:0] imm;
    logic        regdst, regwrite, alusrc, memread, memwrite;
  } instr_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          cyc;
  } exp_t;

  exp_t        q_m[$], q_s[$];
  logic [31:0] rf_m[2][32];
  logic [31:0] dm_m[2][256];
  int          nvec = 0, nfail = 0, cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] op, input int r1, input int r2, input int rd,
                                input logic [15:0] imm, input logic regdst, input logic regwrite,
                                input logic alusrc, input logic memread, input logic memwrite);
    instr_t in;
    in.op = op; in.r1 = r1; in.r2 = r2; in.rd = rd; in.imm = imm;
    in.regdst = regdst; in.regwrite = regwrite; in.alusrc = alusrc;
    in.memread = memread; in.memwrite = memwrite;
    return in;
  endfunction

  // Reference ALU on w-bit operands held in 32-bit containers.
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input int w);
    int sa, sb;
    sa = (w == 16) ? int'($signed(a[15:0])) : int'($signed(a));
    sb = (w == 16) ? int'($signed(b[15:0])) : int'($signed(b));
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd6:  return a - b;
      4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd12: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input instr_t in);
    read1 = 5'(in.r1); read2 = 5'(in.r2); ins_rd = 5'(in.rd); sein = in.imm;
    aluop = in.op; regdst = in.regdst; regwrite = in.regwrite; alusrc = in.alusrc;
    memread = in.memread; memtoreg = in.memread; memwrite = in.memwrite;
  endtask

  task automatic junk();
    read1 = 5'($urandom); read2 = 5'($urandom); ins_rd = 5'($urandom);
    sein = 16'($urandom); aluop = 4'($urandom);
    {regdst, regwrite, alusrc, memtoreg, memwrite, memread} = 6'($urandom);
  endtask

  // Model the instruction, queue its expected response, then run it on the DUT.
  task automatic issue(input instr_t in, input bit sm);
    logic [31:0] mask, a, b, alu, old, wdata;
    int r1, r2, rd, dest, addr, w, n;
    bit mem;
    exp_t e;
    w    = sm ? 16 : 32;
    mask = sm ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    r1   = sm ? in.r1 % 8 : in.r1;
    r2   = sm ? in.r2 % 8 : in.r2;
    rd   = sm ? in.rd % 8 : in.rd;
    a    = rf_m[sm][r1];
    b    = in.alusrc ? ({{16{in.imm[15]}}, in.imm} & mask) : rf_m[sm][r2];
    alu  = alu_ref(in.op, a, b, w) & mask;
    mem  = in.memread | in.memwrite;
    addr = sm ? int'(alu % 16) : int'(alu % 256);
    old  = dm_m[sm][addr];
    if (in.memwrite) dm_m[sm][addr] = rf_m[sm][r2];
    wdata = in.memread ? old : alu;
    dest  = in.regdst ? rd : r2;
    if (in.regwrite && dest != 0) rf_m[sm][dest] = wdata;
    e.res  = in.regwrite ? wdata : alu;
    e.zero = (alu == 32'd0);

    @(negedge clk);
    drive(in);
    if (sm) start_s = 1'b1; else start_m = 1'b1;
    e.cyc = cyc + 1 + (mem ? 2 : 1);
    if (sm) q_s.push_back(e); else q_m.push_back(e);
    // Inputs change and Start pulses while busy; none of it may take effect.
    @(negedge clk);
    junk();
    if (sm) start_s = 1'($urandom); else start_m = 1'($urandom);
    @(negedge clk);
    junk();
    start_m = 1'b0; start_s = 1'b0;
    for (n = 0; n < 12; n++) begin
      if ((sm ? q_s.size() : q_m.size()) == 0) break;
      @(negedge clk);
    end
    if ((sm ? q_s.size() : q_m.size()) != 0) begin
      nvec++; nfail++;
      $display("FAIL done_timeout: no Done within budget, sm=%0d", sm);
      if (sm) q_s.delete(); else q_m.delete();
    end
  endtask

  // Monitor: compare every Done against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && m_done) begin
      if (q_m.size() == 0) chk("m_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_m.pop_front();
        chk("m_result", m_result, e.res);
        chk("m_zero", 32'(m_zero), 32'(e.zero));
        chk("m_done_cycle", cyc, e.cyc);
      end
    end
    if (!rst && s_done) begin
      if (q_s.size() == 0) chk("s_unexpected_done", 32'd1, 32'd0);
      else begin
        e = q_s.pop_front();
        chk("s_result", {16'd0, s_result}, e.res);
        chk("s_zero", 32'(s_zero), 32'(e.zero));
        chk("s_done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    instr_t in;
    int     r;
    foreach (rf_m[i, j]) rf_m[i][j] = '0;
    foreach (dm_m[i, j]) dm_m[i][j] = '0;
    rst = 1'b1; start_m = 1'b0; start_s = 1'b0;
    junk();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(m_busy), 32'd0);
    chk("rst_done", 32'(m_done), 32'd0);
    chk("rst_result", m_result, 32'd0);
    chk("rst_zero", 32'(m_zero), 32'd0);
    rst = 1'b0;

    // Directed: ADDI, SUB to rd, sign-extended immediate.
    issue(mk(4'b0010, 0, 3, 0, 16'h0005, 0, 1, 1, 0, 0), 0);
    issue(mk(4'b0110, 3, 3, 4, 16'h0000, 1, 1, 0, 0, 0), 0);
    issue(mk(4'b0010, 0, 6, 0, 16'hFFFF, 0, 1, 1, 0, 0), 0);
    // SW R3 -> 0x104 (word 4), LW R5, combined read/write on the same word.
    issue(mk(4'b0010, 0, 3, 0, 16'h0104, 0, 0, 1, 0, 1), 0);
    issue(mk(4'b0010, 0, 5, 0, 16'h0104, 0, 1, 1, 1, 0), 0);
    issue(mk(4'b0010, 0, 6, 0, 16'h0004, 0, 1, 1, 1, 1), 0);
    issue(mk(4'b0010, 0, 7, 0, 16'h0004, 0, 1, 1, 1, 0), 0);
    // R0 write is dropped; reading R0 back.
    issue(mk(4'b0010, 0, 0, 0, 16'h0007, 0, 1, 1, 0, 0), 0);
    issue(mk(4'b0010, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0), 0);
    // SLT -1 < 1, undefined op.
    issue(mk(4'b0010, 0, 8, 0, 16'hFFFF, 0, 1, 1, 0, 0), 0);
    issue(mk(4'b0010, 0, 9, 0, 16'h0001, 0, 1, 1, 0, 0), 0);
    issue(mk(4'b0111, 8, 9, 10, 16'h0000, 1, 1, 0, 0, 0), 0);
    issue(mk(4'b1111, 8, 9, 11, 16'h1234, 1, 1, 0, 0, 0), 0);

    // Fill registers and every memory word so later loads are defined.
    for (int i = 1; i < 32; i++) issue(mk(4'b0010, 0, i, 0, 16'($urandom), 0, 1, 1, 0, 0), 0);
    for (int i = 0; i < 256; i++)
      issue(mk(4'b0010, 0, int'($urandom_range(31, 1)), 0, 16'(i), 0, 0, 1, 0, 1), 0);

    // Random instruction mix.
    for (int i = 0; i < 200; i++) begin
      logic [3:0] ops [7];
      ops = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'($urandom)};
      in = mk(ops[$urandom_range(6, 0)], int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
              int'($urandom_range(31, 0)), 16'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0));
      issue(in, 0);
    end

    // Reset during the MEM cycle of a store: nothing may commit.
    r = 1;
    for (int i = 1; i < 32; i++) if (rf_m[0][i] != dm_m[0][16]) r = i;
    @(negedge clk);
    drive(mk(4'b0010, 0, r, 0, 16'h0010, 0, 0, 1, 0, 1));
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(m_busy), 32'd0);
    chk("midrst_done", 32'(m_done), 32'd0);
    chk("midrst_result", m_result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    foreach (rf_m[i, j]) rf_m[i][j] = '0;
    for (int i = 0; i < 32; i++) issue(mk(4'b0010, i, 0, 0, 16'h0000, 0, 0, 0, 0, 0), 0);
    issue(mk(4'b0010, 0, 1, 0, 16'h0010, 0, 1, 1, 1, 0), 0);

    // Narrow instance: same first scenario, results truncated to 16 bits.
    issue(mk(4'b0010, 0, 3, 0, 16'h0005, 0, 1, 1, 0, 0), 1);
    issue(mk(4'b0110, 3, 3, 4, 16'h0000, 1, 1, 0, 0, 0), 1);
    issue(mk(4'b0010, 0, 6, 0, 16'hFFFF, 0, 1, 1, 0, 0), 1);
    issue(mk(4'b0010, 0, 3, 0, 16'h0014, 0, 0, 1, 0, 1), 1);
    issue(mk(4'b0010, 0, 5, 0, 16'h0004, 0, 1, 1, 1, 0), 1);
    issue(mk(4'b0111, 6, 3, 7, 16'h0000, 1, 1, 0, 0, 0), 1);
    issue(mk(4'b0010, 5, 0, 0, 16'h0000, 0, 0, 0, 0, 0), 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
